floor_fifo_ctrl: RTL and testbench

Pointer and flag controller for the elevator's floor-request FIFO. It sits between the request inputs and the call scheduler, and it is the only block that drives the dual-port request RAM. It accepts push requests carrying a floor number and turns them into RAM write-enable, write-data and write-pointer. It accepts pops from the scheduler and advances the read pointer. It reports full, empty, occupancy, and sticky overflow/underflow errors, and it drops back-to-back duplicate floor requests.

---
 rtl/floor_fifo_pkg.sv | 13 +
 rtl/floor_fifo_ptr.sv | 28 ++
 rtl/floor_fifo_ctrl.sv | 130 +++++++++++++
 tb/tb_floor_fifo_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/floor_fifo_pkg.sv
// Shared constants for the floor-request FIFO controller.
// Holds the default floor width, depth and pointer width, plus the derived
// occupancy-counter width (one extra bit so that "full" is representable).
package floor_fifo_pkg;

  localparam int unsigned FIFO_FLOOR_WIDTH   = 4;
  localparam int unsigned FIFO_DEPTH         = 16;
  localparam int unsigned FIFO_POINTER_WIDTH = 4;

  // Occupancy runs 0..depth, so it needs one bit more than a RAM address.
  localparam int unsigned fifo_pCOUNT_WIDTH  = FIFO_POINTER_WIDTH + 1;

endpackage : floor_fifo_pkg

// File: rtl/floor_fifo_ptr.sv
// Wrapping RAM pointer for the floor-request FIFO.
// Ports:
//   i_clock    - rising-edge clock
//   i_reset_n  - asynchronous active-low reset, pointer returns to 0
//   i_advance  - step the pointer by one this cycle
//   o_pointer  - current RAM address
// The depth is a power of two, so the wrap from depth-1 to 0 is plain
// binary overflow of the pointer register.
module floor_fifo_ptr
  import floor_fifo_pkg::*;
#(
  parameter int fifo_pPOINTER_WIDTH = FIFO_POINTER_WIDTH
) (
  input  logic                           i_clock,
  input  logic                           i_reset_n,
  input  logic                           i_advance,
  output logic [fifo_pPOINTER_WIDTH-1:0] o_pointer
);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pointer <= '0;
    end else if (i_advance) begin
      o_pointer <= o_pointer + fifo_pPOINTER_WIDTH'(1);
    end
  end

endmodule : floor_fifo_ptr

// File: rtl/floor_fifo_ctrl.sv
// Pointer and flag controller for the elevator floor-request FIFO.
// It is the only driver of the dual-port request RAM owned by the parent.
// Ports:
//   i_clock, i_reset_n - clock and asynchronous active-low reset
//   i_push, i_push_floor - enqueue one floor number
//   i_pop              - scheduler consumed the head entry (RAM[rd_pointer])
//   o_wr_en, o_wr_data, wr_pointer - RAM write port, valid in the push cycle
//   rd_pointer         - RAM read address of the head entry
//   o_rd_en            - pop accepted this cycle
//   o_full, o_empty, o_count - occupancy, registered
//   o_dup              - pulse: push dropped as a repeat of the last floor
//   o_overflow         - sticky: push refused while full
//   o_underflow        - sticky: pop refused while empty
module floor_fifo_ctrl
  import floor_fifo_pkg::*;
#(
  parameter int fifo_pFLOOR_WIDTH   = FIFO_FLOOR_WIDTH,
  parameter int fifo_pFIFO_DEPTH    = FIFO_DEPTH,
  parameter int fifo_pPOINTER_WIDTH = FIFO_POINTER_WIDTH
) (
  input  logic                           i_clock,
  input  logic                           i_reset_n,
  input  logic                           i_push,
  input  logic [fifo_pFLOOR_WIDTH-1:0]   i_push_floor,
  input  logic                           i_pop,
  output logic                           o_wr_en,
  output logic [fifo_pFLOOR_WIDTH-1:0]   o_wr_data,
  output logic [fifo_pPOINTER_WIDTH-1:0] wr_pointer,
  output logic [fifo_pPOINTER_WIDTH-1:0] rd_pointer,
  output logic                           o_rd_en,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [fifo_pPOINTER_WIDTH:0]   o_count,
  output logic                           o_dup,
  output logic                           o_overflow,
  output logic                           o_underflow
);

  localparam int CW = fifo_pPOINTER_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(fifo_pFIFO_DEPTH);

  logic [CW-1:0]                count_p0;
  logic [CW-1:0]                count_next;
  logic [fifo_pFLOOR_WIDTH-1:0] last_floor_p0;
  logic                         last_valid_p0;
  logic                         overflow_p0;
  logic                         underflow_p0;

  logic pop_ok;
  logic push_ok;
  logic dup;
  logic full;
  logic empty;

  assign full  = (count_p0 == DEPTH_C);
  assign empty = (count_p0 == '0);

  // Request cycle: accept/refuse decisions and RAM write port, no latency.
  assign pop_ok = i_pop & ~empty;
  // A repeat is only meaningful while the previous floor is still queued.
  assign dup    = i_push & last_valid_p0 & ~empty & (i_push_floor == last_floor_p0);
  // A concurrent pop frees the slot being written, so full does not block.
  assign push_ok = i_push & ~dup & (~full | pop_ok);

  assign o_wr_en   = push_ok;
  assign o_wr_data = push_ok ? i_push_floor : '0;
  assign o_rd_en   = pop_ok;
  assign o_dup     = dup;

  always_comb begin
    count_next = count_p0;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_p0 + CW'(1);
      2'b01:   count_next = count_p0 - CW'(1);
      default: count_next = count_p0;
    endcase
  end

  floor_fifo_ptr #(
    .fifo_pPOINTER_WIDTH(fifo_pPOINTER_WIDTH)
  ) u_wr_ptr (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_advance(push_ok),
    .o_pointer(wr_pointer)
  );

  floor_fifo_ptr #(
    .fifo_pPOINTER_WIDTH(fifo_pPOINTER_WIDTH)
  ) u_rd_ptr (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_advance(pop_ok),
    .o_pointer(rd_pointer)
  );

  // State update on the edge after the request cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_p0      <= '0;
      last_floor_p0 <= '0;
      last_valid_p0 <= 1'b0;
      overflow_p0   <= 1'b0;
      underflow_p0  <= 1'b0;
    end else begin
      count_p0 <= count_next;
      if (push_ok) begin
        last_floor_p0 <= i_push_floor;
        last_valid_p0 <= 1'b1;
      end else if (pop_ok && count_p0 == CW'(1)) begin
        // Draining the last entry forgets the floor, so the same floor
        // can be requested again.
        last_valid_p0 <= 1'b0;
      end
      if (i_push && !dup && !push_ok) begin
        overflow_p0 <= 1'b1;
      end
      if (i_pop && !pop_ok) begin
        underflow_p0 <= 1'b1;
      end
    end
  end

  assign o_count     = count_p0;
  assign o_full      = full;
  assign o_empty     = empty;
  assign o_overflow  = overflow_p0;
  assign o_underflow = underflow_p0;

endmodule : floor_fifo_ctrl

// File: tb/tb_floor_fifo_ctrl.sv
module tb_floor_fifo_ctrl;

  logic       i_clock = 1'b0;
  logic       i_reset_n;
  logic       i_push;
  logic [3:0] i_push_floor;
  logic       i_pop;
  logic       o_wr_en;
  logic [3:0] o_wr_data;
  logic [3:0] wr_pointer;
  logic [3:0] rd_pointer;
  logic       o_rd_en;
  logic       o_full;
  logic       o_empty;
  logic [4:0] o_count;
  logic       o_dup;
  logic       o_overflow;
  logic       o_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] ram [16];

  floor_fifo_ctrl dut (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_push      (i_push),
    .i_push_floor(i_push_floor),
    .i_pop       (i_pop),
    .o_wr_en     (o_wr_en),
    .o_wr_data   (o_wr_data),
    .wr_pointer  (wr_pointer),
    .rd_pointer  (rd_pointer),
    .o_rd_en     (o_rd_en),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_count     (o_count),
    .o_dup       (o_dup),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 i_clock = ~i_clock;

  // Model of the parent's request RAM.
  always @(posedge i_clock) begin
    if (o_wr_en) ram[wr_pointer] <= o_wr_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit       push;
    bit [3:0] floor;
    bit       pop;
    bit       e_wr_en;
    bit [3:0] e_wr_data;
    bit       e_rd_en;
    bit       e_dup;
    bit       chk_head;
    bit [3:0] e_head;
    bit [4:0] e_count;
    bit       e_full;
    bit       e_empty;
    bit [3:0] e_wp;
    bit [3:0] e_rp;
    bit       e_ovf;
    bit       e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit push, bit [3:0] floor, bit pop,
                              bit wr_en, bit [3:0] wr_data, bit rd_en, bit dup,
                              bit chk_head, bit [3:0] head,
                              bit [4:0] cnt, bit full, bit empty,
                              bit [3:0] wp, bit [3:0] rp, bit ovf, bit unf);
    vec_t v;
    v.push = push; v.floor = floor; v.pop = pop;
    v.e_wr_en = wr_en; v.e_wr_data = wr_data; v.e_rd_en = rd_en; v.e_dup = dup;
    v.chk_head = chk_head; v.e_head = head;
    v.e_count = cnt; v.e_full = full; v.e_empty = empty;
    v.e_wp = wp; v.e_rp = rp; v.e_ovf = ovf; v.e_unf = unf;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input int cnt, input int full, input int empty,
                             input int wp, input int rp, input int ovf, input int unf);
    check({tag, " count"},     int'(o_count),     cnt);
    check({tag, " full"},      int'(o_full),      full);
    check({tag, " empty"},     int'(o_empty),     empty);
    check({tag, " wr_pointer"}, int'(wr_pointer), wp);
    check({tag, " rd_pointer"}, int'(rd_pointer), rp);
    check({tag, " overflow"},  int'(o_overflow),  ovf);
    check({tag, " underflow"}, int'(o_underflow), unf);
  endtask

  task automatic check_comb(input string tag, input int wr_en, input int wr_data,
                            input int rd_en, input int dup);
    check({tag, " wr_en"},   int'(o_wr_en),   wr_en);
    check({tag, " wr_data"}, int'(o_wr_data), wr_data);
    check({tag, " rd_en"},   int'(o_rd_en),   rd_en);
    check({tag, " dup"},     int'(o_dup),     dup);
  endtask

  initial begin
    string tag;
    i_reset_n = 1'b0; i_push = 1'b0; i_push_floor = '0; i_pop = 1'b0;

    // Basic fill / drain of floors 3,5,7
    vecs.push_back(mk(1,3,0, 1,3,0,0, 0,0, 1,0,0, 1,0, 0,0));
    vecs.push_back(mk(1,5,0, 1,5,0,0, 1,3, 2,0,0, 2,0, 0,0));
    vecs.push_back(mk(1,7,0, 1,7,0,0, 1,3, 3,0,0, 3,0, 0,0));
    vecs.push_back(mk(0,0,1, 0,0,1,0, 1,3, 2,0,0, 3,1, 0,0));
    vecs.push_back(mk(0,0,1, 0,0,1,0, 1,5, 1,0,0, 3,2, 0,0));
    vecs.push_back(mk(0,0,1, 0,0,1,0, 1,7, 0,0,1, 3,3, 0,0));
    // Empty: refused pop, then push+pop together
    vecs.push_back(mk(0,0,1, 0,0,0,0, 0,0, 0,0,1, 3,3, 0,1));
    vecs.push_back(mk(1,9,1, 1,9,0,0, 0,0, 1,0,0, 4,3, 0,1));
    // Duplicates
    vecs.push_back(mk(1,9,0, 0,0,0,1, 1,9, 1,0,0, 4,3, 0,1));
    vecs.push_back(mk(1,4,0, 1,4,0,0, 1,9, 2,0,0, 5,3, 0,1));
    vecs.push_back(mk(1,4,0, 0,0,0,1, 1,9, 2,0,0, 5,3, 0,1));
    vecs.push_back(mk(1,6,0, 1,6,0,0, 1,9, 3,0,0, 6,3, 0,1));
    vecs.push_back(mk(1,4,0, 1,4,0,0, 1,9, 4,0,0, 7,3, 0,1));
    vecs.push_back(mk(0,0,1, 0,0,1,0, 1,9, 3,0,0, 7,4, 0,1));
    vecs.push_back(mk(0,0,1, 0,0,1,0, 1,4, 2,0,0, 7,5, 0,1));
    vecs.push_back(mk(0,0,1, 0,0,1,0, 1,6, 1,0,0, 7,6, 0,1));
    vecs.push_back(mk(0,0,1, 0,0,1,0, 1,4, 0,0,1, 7,7, 0,1));
    // Same floor after draining is accepted
    vecs.push_back(mk(1,4,0, 1,4,0,0, 0,0, 1,0,0, 8,7, 0,1));
    vecs.push_back(mk(0,0,1, 0,0,1,0, 1,4, 0,0,1, 8,8, 0,1));
    // Fill to full with alternating floors from address 8
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1, 4'(i % 2), 0, 1, 4'(i % 2), 0, 0, (i > 0), 0,
                        5'(i + 1), (i == 15), 0, 4'((9 + i) % 16), 8, 0, 1));
    // Push while full is refused
    vecs.push_back(mk(1,0,0, 0,0,0,0, 1,0, 16,1,0, 8,8, 1,1));
    // Push and pop together while full; pointers wrap 15 -> 0 on the last one
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1, 4'(k % 2), 1, 1, 4'(k % 2), 1, 0, 1, 4'(k % 2),
                        16, 1, 0, 4'((9 + k) % 16), 4'((9 + k) % 16), 1, 1));
    // Drain down to 9 entries
    for (int j = 0; j < 7; j++)
      vecs.push_back(mk(0,0,1, 0,0,1,0, 0,0, 5'(15 - j), 0, 0, 0, 4'(j + 1), 1, 1));

    repeat (2) @(posedge i_clock);
    #1;
    check_state("reset", 0, 1'b0, 1'b1, 0, 0, 0, 0);
    check_comb("reset", 0, 0, 0, 0);
    @(negedge i_clock);
    i_reset_n = 1'b1;

    foreach (vecs[n]) begin
      @(negedge i_clock);
      i_push = vecs[n].push; i_push_floor = vecs[n].floor; i_pop = vecs[n].pop;
      #2;
      tag = $sformatf("vec%0d", n);
      check_comb(tag, vecs[n].e_wr_en, vecs[n].e_wr_data, vecs[n].e_rd_en, vecs[n].e_dup);
      if (vecs[n].chk_head) check({tag, " head"}, int'(ram[rd_pointer]), vecs[n].e_head);
      @(posedge i_clock);
      #1;
      check_state(tag, vecs[n].e_count, vecs[n].e_full, vecs[n].e_empty,
                  vecs[n].e_wp, vecs[n].e_rp, vecs[n].e_ovf, vecs[n].e_unf);
    end

    // Reset in the middle of a cycle with count=9 and both sticky flags set
    @(negedge i_clock);
    i_push = 1'b0; i_pop = 1'b0; i_push_floor = '0;
    #2;
    i_reset_n = 1'b0;
    #1;
    check_state("midreset", 0, 1'b0, 1'b1, 0, 0, 0, 0);
    check_comb("midreset", 0, 0, 0, 0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    @(negedge i_clock);
    i_push = 1'b1; i_push_floor = 4'd2;
    #2;
    check_comb("post_reset_push", 1, 2, 0, 0);
    check("post_reset_push wr_pointer", int'(wr_pointer), 0);
    @(posedge i_clock);
    #1;
    check_state("post_reset_push", 1, 1'b0, 1'b0, 1, 0, 0, 0);
    @(negedge i_clock);
    i_push = 1'b0;
    #2;
    check("post_reset head", int'(ram[rd_pointer]), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_floor_fifo_ctrl
